// File: rtl/sp_ram_arb_pkg.sv
// Shared types for the two-master single-port RAM arbiter.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package sp_ram_arb_pkg;

    // Master identifiers: M0 = core data port, M1 = debug/loader port.
    typedef enum logic {
        MST_M0 = 1'b0,
        MST_M1 = 1'b1
    } mst_id_e;

    // Single response stage. It records who was granted and how the beat
    // must be answered one cycle later.
    typedef struct packed {
        logic    valid;  // a grant happened in the previous cycle
        mst_id_e id;     // master that owns the response
        logic    err;    // address was outside the RAM
        logic    rd;     // in-range read: return RAM data
    } resp_t;

    // Returns the opposite master. Used to rotate the round-robin pointer.
    function automatic mst_id_e other_mst(input mst_id_e m);
        return (m == MST_M0) ? MST_M1 : MST_M0;
    endfunction

endpackage

// File: rtl/sp_ram_arbiter.sv
// Two-master round-robin arbiter and sole driver of a 1-cycle-latency single-port RAM.
// Latency: grant is combinational in the request cycle; rvalid/rdata/err follow one cycle later.
// Backpressure: a master holds its request until granted; responses are never stalled.
//
// Ports:
//   clk, rstn_i                     clock, synchronous active-low reset
//   mN_req_i/_gnt_o                 request / same-cycle grant (N = 0, 1)
//   mN_addr_i/_we_i/_be_i/_wdata_i  byte address, write flag, byte enables, write data
//   mN_rvalid_o/_rdata_o/_err_o     one-cycle-later response, read data, range error
//   ram_*                           RAM command (en/addr/we/be/wdata) and read data return
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int unsigned RAM_SIZE   = 32768,
    parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BUS_AW     = 32
) (
    input  logic                    clk,
    input  logic                    rstn_i,

    input  logic                    m0_req_i,
    output logic                    m0_gnt_o,
    input  logic [BUS_AW-1:0]       m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    output logic                    m0_err_o,

    input  logic                    m1_req_i,
    output logic                    m1_gnt_o,
    input  logic [BUS_AW-1:0]       m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    m1_err_o,

    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    localparam int unsigned BE_W = DATA_WIDTH / 8;

    // One extra bit so that RAM_SIZE itself is representable for the compare,
    // even when RAM_SIZE == 2**BUS_AW.
    localparam logic [BUS_AW:0] RAM_LIMIT = (BUS_AW + 1)'(RAM_SIZE);

    // Masters gathered into arrays so the winner can be selected by index.
    logic [1:0]            req;
    logic [BUS_AW-1:0]     addr  [2];
    logic                  we    [2];
    logic [BE_W-1:0]       be    [2];
    logic [DATA_WIDTH-1:0] wdata [2];

    assign req      = {m1_req_i, m0_req_i};
    assign addr[0]  = m0_addr_i;
    assign addr[1]  = m1_addr_i;
    assign we[0]    = m0_we_i;
    assign we[1]    = m1_we_i;
    assign be[0]    = m0_be_i;
    assign be[1]    = m1_be_i;
    assign wdata[0] = m0_wdata_i;
    assign wdata[1] = m1_wdata_i;

    mst_id_e rr_ptr_q, rr_ptr_d;
    resp_t   resp_q, resp_d;

    mst_id_e win;
    logic    win_idx;
    logic    gnt_any;
    logic    in_range;
    logic    rsp_live;

    // Arbitration. Grants are suppressed while reset is asserted so that
    // nothing reaches the RAM during reset.
    always_comb begin
        win      = MST_M0;
        gnt_any  = 1'b0;
        rr_ptr_d = rr_ptr_q;
        if (rstn_i) begin
            unique case (req)
                2'b01: begin
                    win     = MST_M0;
                    gnt_any = 1'b1;
                end
                2'b10: begin
                    win     = MST_M1;
                    gnt_any = 1'b1;
                end
                2'b11: begin
                    // Only contested grants move the pointer, so a lone
                    // requester cannot steal the other master's next turn.
                    win      = rr_ptr_q;
                    gnt_any  = 1'b1;
                    rr_ptr_d = other_mst(rr_ptr_q);
                end
                default: begin
                    win     = MST_M0;
                    gnt_any = 1'b0;
                end
            endcase
        end
    end

    assign win_idx  = win;
    assign m0_gnt_o = gnt_any & (win == MST_M0);
    assign m1_gnt_o = gnt_any & (win == MST_M1);

    // Range check on the full bus address, not on the truncated RAM address.
    assign in_range = ({1'b0, addr[win_idx]} < RAM_LIMIT);

    // RAM command. An out-of-range beat is still granted but never enables the RAM.
    assign ram_en_o    = gnt_any & in_range;
    assign ram_addr_o  = addr[win_idx][ADDR_WIDTH-1:0];
    assign ram_we_o    = gnt_any & we[win_idx];
    assign ram_be_o    = gnt_any ? be[win_idx] : '0;
    assign ram_wdata_o = wdata[win_idx];

    // Response stage loaded every cycle; a cycle without a grant loads an empty slot.
    always_comb begin
        resp_d       = '0;
        resp_d.valid = gnt_any;
        resp_d.id    = win;
        resp_d.err   = gnt_any & ~in_range;
        resp_d.rd    = gnt_any & in_range & ~we[win_idx];
    end

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            rr_ptr_q <= MST_M0;
            resp_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            resp_q   <= resp_d;
        end
    end

    // A response still in the stage when reset arrives is discarded by
    // gating with rstn_i, so it never shows up in the reset cycle itself.
    assign rsp_live = resp_q.valid & rstn_i;

    assign m0_rvalid_o = rsp_live & (resp_q.id == MST_M0);
    assign m1_rvalid_o = rsp_live & (resp_q.id == MST_M1);

    // RAM read data passes straight through; writes and errors return zero.
    assign m0_rdata_o = (m0_rvalid_o & resp_q.rd) ? ram_rdata_i : '0;
    assign m1_rdata_o = (m1_rvalid_o & resp_q.rd) ? ram_rdata_i : '0;
    assign m0_err_o   = m0_rvalid_o & resp_q.err;
    assign m1_err_o   = m1_rvalid_o & resp_q.err;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Self-checking bench for sp_ram_arbiter with a behavioural RAM and a reference model.
// Latency: checks same-cycle grant/RAM command and next-cycle response.
// Backpressure: bench masters hold each request until it is granted.
module tb_sp_ram_arbiter;

    localparam int RAM_SIZE = 32768;
    localparam int WORDS    = RAM_SIZE / 4;

    logic clk = 1'b0;
    logic rstn;

    logic        req   [2];
    logic [31:0] addr  [2];
    logic        we    [2];
    logic [3:0]  be    [2];
    logic [31:0] wdata [2];

    logic        gnt0, gnt1, rv0, rv1, err0, err1;
    logic [31:0] rd0, rd1;

    logic        ram_en, ram_we;
    logic [14:0] ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    always #5 clk = ~clk;

    sp_ram_arbiter dut (
        .clk         (clk),
        .rstn_i      (rstn),
        .m0_req_i    (req[0]),
        .m0_gnt_o    (gnt0),
        .m0_addr_i   (addr[0]),
        .m0_we_i     (we[0]),
        .m0_be_i     (be[0]),
        .m0_wdata_i  (wdata[0]),
        .m0_rvalid_o (rv0),
        .m0_rdata_o  (rd0),
        .m0_err_o    (err0),
        .m1_req_i    (req[1]),
        .m1_gnt_o    (gnt1),
        .m1_addr_i   (addr[1]),
        .m1_we_i     (we[1]),
        .m1_be_i     (be[1]),
        .m1_wdata_i  (wdata[1]),
        .m1_rvalid_o (rv1),
        .m1_rdata_o  (rd1),
        .m1_err_o    (err1),
        .ram_en_o    (ram_en),
        .ram_addr_o  (ram_addr),
        .ram_we_o    (ram_we),
        .ram_be_o    (ram_be),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return {i[15:0] ^ 16'hBEEF, i[15:0]};
    endfunction

    // Behavioural single-port RAM with one cycle of read latency.
    bit          ram_inited = 1'b0;
    logic [31:0] ram_mem [WORDS];

    always @(posedge clk) begin
        if (!ram_inited) begin
            for (int i = 0; i < WORDS; i++) ram_mem[i] <= init_word(i);
            ram_inited <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) ram_mem[ram_addr[14:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= ram_mem[ram_addr[14:2]];
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state.
    logic [31:0] ref_mem [WORDS];
    bit          model_ptr;        // master that wins the next contested cycle
    bit          exp_vld;
    int          exp_id;
    bit          exp_err;
    logic [31:0] exp_rdata;
    int          wait_cnt [2];
    bit          last_gnt [2];
    bit          obs_rv   [2];
    bit          obs_err  [2];
    logic [31:0] obs_rdata[2];
    int          gnt_total = 0;
    int          rv_total  = 0;

    // One clock cycle: inputs are already driven; check at negedge, advance to posedge+1.
    task automatic step();
        int w;
        bit any, inr;
        int idx;
        @(negedge clk);
        if (!rstn) begin
            if (exp_vld) gnt_total--;   // response legitimately discarded by reset
            exp_vld = 1'b0;
        end
        check_val("rvalid0", rv0, exp_vld && exp_id == 0);
        check_val("rvalid1", rv1, exp_vld && exp_id == 1);
        check_val("rvalid_both", rv0 && rv1, 0);
        if (exp_vld) begin
            check_val(exp_id == 0 ? "rdata0" : "rdata1", exp_id == 0 ? rd0 : rd1, exp_rdata);
            check_val(exp_id == 0 ? "err0" : "err1", exp_id == 0 ? err0 : err1, exp_err);
        end
        if (rv0) rv_total++;
        if (rv1) rv_total++;
        obs_rv[0] = rv0;     obs_rv[1] = rv1;
        obs_err[0] = err0;   obs_err[1] = err1;
        obs_rdata[0] = rd0;  obs_rdata[1] = rd1;
        exp_vld = 1'b0;

        if (!rstn) begin
            check_val("rst_gnt0", gnt0, 0);
            check_val("rst_gnt1", gnt1, 0);
            check_val("rst_ram_en", ram_en, 0);
            model_ptr = 1'b0;
            wait_cnt[0] = 0;
            wait_cnt[1] = 0;
        end else begin
            any = req[0] || req[1];
            if (req[0] && req[1]) begin
                w = int'(model_ptr);
                model_ptr = ~model_ptr;
            end else begin
                w = req[1] ? 1 : 0;
            end
            check_val("gnt0", gnt0, any && w == 0);
            check_val("gnt1", gnt1, any && w == 1);
            if (any) begin
                inr = addr[w] < RAM_SIZE;
                check_val("ram_en", ram_en, inr);
                if (inr) begin
                    check_val("ram_addr", ram_addr, addr[w][14:0]);
                    check_val("ram_we", ram_we, we[w]);
                    check_val("ram_be", ram_be, be[w]);
                    if (we[w]) check_val("ram_wdata", ram_wdata, wdata[w]);
                end
                idx = int'(addr[w][14:2]);
                exp_vld   = 1'b1;
                exp_id    = w;
                exp_err   = !inr;
                exp_rdata = (inr && !we[w]) ? ref_mem[idx] : 32'h0;
                if (inr && we[w])
                    for (int b = 0; b < 4; b++)
                        if (be[w][b]) ref_mem[idx][8*b +: 8] = wdata[w][8*b +: 8];
                gnt_total++;
            end else begin
                check_val("idle_ram_en", ram_en, 0);
                check_val("idle_ram_we", ram_we, 0);
                check_val("idle_ram_be", ram_be, 0);
            end
            // Fairness: a pending master never loses more than one cycle in a row.
            for (int n = 0; n < 2; n++) begin
                if (req[n] && !(n == 0 ? gnt0 : gnt1)) wait_cnt[n]++;
                else wait_cnt[n] = 0;
                check_val(n == 0 ? "fair0" : "fair1", wait_cnt[n] > 1, 0);
            end
        end
        last_gnt[0] = gnt0;
        last_gnt[1] = gnt1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int n, input bit r, input logic [31:0] a, input bit w,
                         input logic [3:0] b, input logic [31:0] d);
        req[n] = r; addr[n] = a; we[n] = w; be[n] = b; wdata[n] = d;
    endtask

    task automatic new_random(input int n);
        int r;
        if ($urandom_range(99) < 60) begin
            r = int'($urandom_range(99));
            req[n]   = 1'b1;
            we[n]    = 1'($urandom_range(1));
            be[n]    = 4'($urandom_range(15));
            wdata[n] = $urandom;
            if (r < 10)      addr[n] = $urandom | 32'h0000_8000;
            else if (r < 13) addr[n] = 32'h0000_8000;
            else if (r < 18) addr[n] = 32'(RAM_SIZE - 4) + $urandom_range(3);
            else if (r < 60) addr[n] = $urandom_range(63);
            else             addr[n] = $urandom_range(RAM_SIZE - 1);
        end else begin
            req[n] = 1'b0;
        end
    endtask

    bit gseq [6];

    initial begin
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
        model_ptr = 1'b0;
        exp_vld = 1'b0; exp_id = 0; exp_err = 1'b0; exp_rdata = '0;
        wait_cnt[0] = 0; wait_cnt[1] = 0;
        rstn = 1'b0;
        drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        drive(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        repeat (3) step();
        rstn = 1'b1;
        step();

        // T1: single M0 read of 0x10.
        drive(0, 1'b1, 32'h10, 1'b0, 4'hF, 32'h0);
        step();
        drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        step();
        check_val("t1_rvalid0", obs_rv[0], 1);
        check_val("t1_rdata0", obs_rdata[0], 32'hBEEB_0004);

        // T2: both masters request continuously; grants alternate from M0.
        drive(0, 1'b1, 32'h40, 1'b0, 4'hF, 32'h0);
        drive(1, 1'b1, 32'h44, 1'b0, 4'hF, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            gseq[i] = last_gnt[1];
        end
        for (int i = 0; i < 6; i++) check_val("t2_order", gseq[i], i % 2);
        drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        drive(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        step();

        // T3: partial write then read back through M1.
        drive(1, 1'b1, 32'h20, 1'b1, 4'b0011, 32'hA5A5_1234);
        step();
        drive(1, 1'b1, 32'h20, 1'b0, 4'hF, 32'h0);
        step();
        drive(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        step();
        check_val("t3_rdata1", obs_rdata[1], 32'hBEE7_1234);

        // T4: first out-of-range address.
        drive(0, 1'b1, 32'h0000_8000, 1'b0, 4'hF, 32'h0);
        step();
        drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        step();
        check_val("t4_rvalid0", obs_rv[0], 1);
        check_val("t4_err0", obs_err[0], 1);
        check_val("t4_rdata0", obs_rdata[0], 0);

        // T5: move the pointer to M1, grant M1 alone, then reset.
        drive(0, 1'b1, 32'h80, 1'b0, 4'hF, 32'h0);
        drive(1, 1'b1, 32'h84, 1'b0, 4'hF, 32'h0);
        step();
        drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        step();
        check_val("t5_gnt1", last_gnt[1], 1);
        rstn = 1'b0;
        drive(0, 1'b1, 32'h88, 1'b0, 4'hF, 32'h0);
        step();
        check_val("t5_rv_in_rst", obs_rv[0] | obs_rv[1], 0);
        rstn = 1'b1;
        step();
        check_val("t5_rv_after_rst", obs_rv[0] | obs_rv[1], 0);
        check_val("t5_m0_wins", last_gnt[0], 1);
        drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        step();
        drive(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        step();

        // T6: randomized traffic; masters hold a request until granted.
        for (int c = 0; c < 10000; c++) begin
            for (int n = 0; n < 2; n++)
                if (!req[n] || last_gnt[n]) new_random(n);
            step();
        end
        drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        drive(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        step();
        step();
        check_val("rv_per_gnt", rv_total, gnt_total);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
